// File: rtl/jesd207_burst_sched_if.sv
// jesd207_burst_sched_if
// Bundles the signals around the JESD207 burst scheduler.
//   master : host request logic plus FIFO flags (drives requests, lengths, flags)
//   slave  : the scheduler (drives TXNRX, ENABLE, FIFO enables, status pulses)
// Signals:
//   tx_req/tx_len, rx_req/rx_len : burst requests and lengths in words
//   fifo_rempty, fifo_wfull, fifo_prog_full : FIFO status flags
//   tx_nrx, jesd_en               : JESD207 TXNRX and pulse-mode ENABLE
//   fifo_rd_en, fifo_wr_en        : gated FIFO enables for TX / RX data
//   busy, done, err_underflow, err_overflow : status outputs
interface jesd207_burst_sched_if #(
  parameter int LW = 8
);
  logic          tx_req;
  logic [LW-1:0] tx_len;
  logic          rx_req;
  logic [LW-1:0] rx_len;
  logic          fifo_rempty;
  logic          fifo_wfull;
  logic          fifo_prog_full;
  logic          tx_nrx;
  logic          jesd_en;
  logic          fifo_rd_en;
  logic          fifo_wr_en;
  logic          busy;
  logic          done;
  logic          err_underflow;
  logic          err_overflow;

  modport master (
    output tx_req, tx_len, rx_req, rx_len,
    output fifo_rempty, fifo_wfull, fifo_prog_full,
    input  tx_nrx, jesd_en, fifo_rd_en, fifo_wr_en,
    input  busy, done, err_underflow, err_overflow
  );

  modport slave (
    input  tx_req, tx_len, rx_req, rx_len,
    input  fifo_rempty, fifo_wfull, fifo_prog_full,
    output tx_nrx, jesd_en, fifo_rd_en, fifo_wr_en,
    output busy, done, err_underflow, err_overflow
  );
endinterface

// File: rtl/jesd207_burst_sched.sv
// jesd207_burst_sched
// Sequences JESD207 bursts between the baseband FIFO and the RF data port and
// round-robin arbitrates between a TX and an RX burst requester.
// Ports:
//   fclk : control clock, all state changes on the falling edge
//   rstn : asynchronous active-low reset
//   bus  : jesd207_burst_sched_if.slave (requests, FIFO flags, JESD207 pins,
//          FIFO enables, busy/done/error status)
// Burst sequence: IDLE -> SETUP -> EN_START -> LEAD -> XFER -> EN_STOP -> GUARD.
// Every output is a flop loaded from next-state logic, so the async reset drops
// ENABLE and the FIFO enables immediately.
module jesd207_burst_sched #(
  parameter int LW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int LEAD_CYC  = 2,
  parameter int GUARD_CYC = 4
) (
  input  logic                 fclk,
  input  logic                 rstn,
  jesd207_burst_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_EN_START = 3'd2;
  localparam logic [2:0] S_LEAD     = 3'd3;
  localparam logic [2:0] S_XFER     = 3'd4;
  localparam logic [2:0] S_EN_STOP  = 3'd5;
  localparam logic [2:0] S_GUARD    = 3'd6;

  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

  // The grant edge itself is the TXNRX transition cycle; loading SETUP_CYC
  // (not SETUP_CYC-1) gives SETUP_CYC fully settled cycles after it before
  // the start pulse. LEAD and GUARD count their own cycles directly.
  localparam logic [7:0]    SETUP_LOAD = 8'(SETUP_CYC);
  localparam logic [7:0]    LEAD_LOAD  = 8'(LEAD_CYC - 1);
  localparam logic [7:0]    GUARD_LOAD = 8'(GUARD_CYC - 1);
  localparam logic [LW-1:0] WORD_ONE   = LW'(1);

  logic [2:0]    state_reg,      state_next;
  logic [7:0]    cyc_cnt_reg,    cyc_cnt_next;
  logic [LW-1:0] word_cnt_reg,   word_cnt_next;
  logic [LW-1:0] len_reg,        len_next;
  logic          last_grant_reg, last_grant_next;
  logic          tx_nrx_reg,     tx_nrx_next;
  logic          jesd_en_reg,    jesd_en_next;
  logic          rd_en_reg,      rd_en_next;
  logic          wr_en_reg,      wr_en_next;
  logic          busy_reg,       busy_next;
  logic          done_reg,       done_next;
  logic          err_uf_reg,     err_uf_next;
  logic          err_of_reg,     err_of_next;

  logic tx_elig;
  logic rx_elig;
  logic grant_tx;
  logic grant_rx;

  // RX eligibility uses the programmable-full flag so a burst is only started
  // with headroom; the hard full flag is the in-burst abort condition.
  assign tx_elig = bus.tx_req && (bus.tx_len != '0) && !bus.fifo_rempty;
  assign rx_elig = bus.rx_req && (bus.rx_len != '0) && !bus.fifo_prog_full;

  // On contention the side that did not win last time is granted.
  assign grant_tx = tx_elig && (!rx_elig || (last_grant_reg == DIR_RX));
  assign grant_rx = rx_elig && (!tx_elig || (last_grant_reg == DIR_TX));

  always_comb begin
    state_next      = state_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    len_next        = len_reg;
    last_grant_next = last_grant_reg;
    tx_nrx_next     = tx_nrx_reg;
    jesd_en_next    = 1'b0;
    rd_en_next      = 1'b0;
    wr_en_next      = 1'b0;
    done_next       = 1'b0;
    err_uf_next     = 1'b0;
    err_of_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (grant_tx) begin
          state_next      = S_SETUP;
          cyc_cnt_next    = SETUP_LOAD;
          len_next        = bus.tx_len;
          tx_nrx_next     = DIR_TX;
          last_grant_next = DIR_TX;
        end else if (grant_rx) begin
          state_next      = S_SETUP;
          cyc_cnt_next    = SETUP_LOAD;
          len_next        = bus.rx_len;
          tx_nrx_next     = DIR_RX;
          last_grant_next = DIR_RX;
        end
      end

      S_SETUP: begin
        if (cyc_cnt_reg == 8'd0) begin
          state_next   = S_EN_START;
          jesd_en_next = 1'b1;
        end else begin
          cyc_cnt_next = cyc_cnt_reg - 8'd1;
        end
      end

      S_EN_START: begin
        state_next   = S_LEAD;
        cyc_cnt_next = LEAD_LOAD;
      end

      S_LEAD: begin
        if (cyc_cnt_reg == 8'd0) begin
          state_next    = S_XFER;
          word_cnt_next = len_reg - WORD_ONE;
          rd_en_next    = tx_nrx_reg;
          wr_en_next    = !tx_nrx_reg;
        end else begin
          cyc_cnt_next = cyc_cnt_reg - 8'd1;
        end
      end

      S_XFER: begin
        // Abort is checked before the last-word test so an empty/full flag on
        // the final word still reports the error.
        if (tx_nrx_reg && bus.fifo_rempty) begin
          state_next   = S_EN_STOP;
          jesd_en_next = 1'b1;
          err_uf_next  = 1'b1;
        end else if (!tx_nrx_reg && bus.fifo_wfull) begin
          state_next   = S_EN_STOP;
          jesd_en_next = 1'b1;
          err_of_next  = 1'b1;
        end else if (word_cnt_reg == '0) begin
          state_next   = S_EN_STOP;
          jesd_en_next = 1'b1;
        end else begin
          word_cnt_next = word_cnt_reg - WORD_ONE;
          rd_en_next    = rd_en_reg;
          wr_en_next    = wr_en_reg;
        end
      end

      S_EN_STOP: begin
        state_next   = S_GUARD;
        cyc_cnt_next = GUARD_LOAD;
        done_next    = 1'b1;
      end

      S_GUARD: begin
        if (cyc_cnt_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          cyc_cnt_next = cyc_cnt_reg - 8'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(negedge fclk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      cyc_cnt_reg    <= 8'd0;
      word_cnt_reg   <= '0;
      len_reg        <= '0;
      last_grant_reg <= DIR_RX;
      tx_nrx_reg     <= 1'b1;
      jesd_en_reg    <= 1'b0;
      rd_en_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_uf_reg     <= 1'b0;
      err_of_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      len_reg        <= len_next;
      last_grant_reg <= last_grant_next;
      tx_nrx_reg     <= tx_nrx_next;
      jesd_en_reg    <= jesd_en_next;
      rd_en_reg      <= rd_en_next;
      wr_en_reg      <= wr_en_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_uf_reg     <= err_uf_next;
      err_of_reg     <= err_of_next;
    end
  end

  assign bus.tx_nrx        = tx_nrx_reg;
  assign bus.jesd_en       = jesd_en_reg;
  assign bus.fifo_rd_en    = rd_en_reg;
  assign bus.fifo_wr_en    = wr_en_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.err_underflow = err_uf_reg;
  assign bus.err_overflow  = err_of_reg;

endmodule

// File: tb/tb_jesd207_burst_sched.sv
// tb_jesd207_burst_sched
// Directed bench for jesd207_burst_sched. The DUT updates on the falling edge;
// the bench drives and samples on the rising edge. A burst trace records each
// output as a bit mask where bit k is the value after the k-th falling edge
// counted from the grant edge (k = 0), and is compared to hand-computed masks.
module tb_jesd207_burst_sched;

  logic fclk;
  logic rstn;
  int   n_assert;
  int   n_fail;

  logic [63:0] t_jesd, t_rd, t_wr, t_busy, t_done, t_txnrx, t_uf, t_of;
  logic [63:0] e_jesd, e_rd, e_wr, e_busy, e_done, e_txnrx;

  jesd207_burst_sched_if #(.LW(8)) bus_if ();

  jesd207_burst_sched #(
    .LW(8), .SETUP_CYC(2), .LEAD_CYC(2), .GUARD_CYC(4)
  ) dut (
    .fclk(fclk),
    .rstn(rstn),
    .bus (bus_if)
  );

  initial fclk = 1'b1;
  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records n cycles of outputs. Unless hold is set, requests drop (and lengths
  // change) right after the grant. At cycle ev_k, code 1 raises fifo_rempty and
  // code 2 raises fifo_wfull.
  task automatic capture(input int n, input bit hold, input int ev_k, input int ev_code);
    t_jesd = '0; t_rd = '0; t_wr = '0; t_busy = '0;
    t_done = '0; t_txnrx = '0; t_uf = '0; t_of = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge fclk);
      t_jesd[k]  = bus_if.jesd_en;
      t_rd[k]    = bus_if.fifo_rd_en;
      t_wr[k]    = bus_if.fifo_wr_en;
      t_busy[k]  = bus_if.busy;
      t_done[k]  = bus_if.done;
      t_txnrx[k] = bus_if.tx_nrx;
      t_uf[k]    = bus_if.err_underflow;
      t_of[k]    = bus_if.err_overflow;
      if (!hold && k == 0) begin
        bus_if.tx_req = 1'b0;
        bus_if.rx_req = 1'b0;
        bus_if.tx_len = 8'd9;
        bus_if.rx_len = 8'd9;
      end
      if (k == ev_k && ev_code == 1) bus_if.fifo_rempty = 1'b1;
      if (k == ev_k && ev_code == 2) bus_if.fifo_wfull  = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (bus_if.busy && cnt < 40) begin
      @(posedge fclk);
      cnt++;
    end
    chk("idle_wait_busy", 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstn = 1'b0;
    bus_if.tx_req = 1'b0;  bus_if.tx_len = 8'd0;
    bus_if.rx_req = 1'b0;  bus_if.rx_len = 8'd0;
    bus_if.fifo_rempty = 1'b0;
    bus_if.fifo_wfull = 1'b0;
    bus_if.fifo_prog_full = 1'b0;
    repeat (3) @(posedge fclk);

    // Reset values
    chk("rst_tx_nrx",  64'(bus_if.tx_nrx), 64'd1);
    chk("rst_jesd_en", 64'(bus_if.jesd_en), 64'd0);
    chk("rst_rd_en",   64'(bus_if.fifo_rd_en), 64'd0);
    chk("rst_wr_en",   64'(bus_if.fifo_wr_en), 64'd0);
    chk("rst_busy",    64'(bus_if.busy), 64'd0);
    chk("rst_done",    64'(bus_if.done), 64'd0);
    chk("rst_err_uf",  64'(bus_if.err_underflow), 64'd0);
    chk("rst_err_of",  64'(bus_if.err_overflow), 64'd0);
    rstn = 1'b1;
    @(posedge fclk);

    // TX burst, len 5: pulses at 3 and 11, rd_en 6..10, done 12, idle at 16
    bus_if.tx_len = 8'd5; bus_if.tx_req = 1'b1;
    capture(20, 1'b0, -1, 0);
    chk("tx_txnrx", t_txnrx, 64'hFFFFF);
    chk("tx_jesd",  t_jesd,  64'h00808);
    chk("tx_rd_en", t_rd,    64'h007C0);
    chk("tx_wr_en", t_wr,    64'h0);
    chk("tx_done",  t_done,  64'h01000);
    chk("tx_busy",  t_busy,  64'h0FFFF);
    chk("tx_err",   t_uf | t_of, 64'h0);

    // RX burst, len 3: pulses at 3 and 9, wr_en 6..8, done 10, idle at 14
    bus_if.rx_len = 8'd3; bus_if.rx_req = 1'b1;
    capture(20, 1'b0, -1, 0);
    chk("rx_txnrx", t_txnrx, 64'h0);
    chk("rx_jesd",  t_jesd,  64'h00208);
    chk("rx_wr_en", t_wr,    64'h001C0);
    chk("rx_rd_en", t_rd,    64'h0);
    chk("rx_done",  t_done,  64'h00400);
    chk("rx_busy",  t_busy,  64'h03FFF);

    // RX overflow, len 4: wfull raised in 2nd XFER cycle, abort at edge 8
    bus_if.rx_len = 8'd4; bus_if.rx_req = 1'b1;
    capture(20, 1'b0, 7, 2);
    bus_if.fifo_wfull = 1'b0;
    chk("of_wr_en", t_wr,   64'h000C0);
    chk("of_err",   t_of,   64'h00100);
    chk("of_no_uf", t_uf,   64'h0);
    chk("of_jesd",  t_jesd, 64'h00108);
    chk("of_done",  t_done, 64'h00200);
    chk("of_busy",  t_busy, 64'h01FFF);

    // TX underflow, len 10: rempty raised in 4th XFER cycle, abort at edge 10
    bus_if.tx_len = 8'd10; bus_if.tx_req = 1'b1;
    capture(20, 1'b0, 9, 1);
    bus_if.fifo_rempty = 1'b0;
    chk("uf_rd_en", t_rd,   64'h003C0);
    chk("uf_err",   t_uf,   64'h00400);
    chk("uf_no_of", t_of,   64'h0);
    chk("uf_jesd",  t_jesd, 64'h00408);
    chk("uf_done",  t_done, 64'h00800);
    chk("uf_busy",  t_busy, 64'h07FFF);

    // Contention after reset: TX, RX, TX, RX with 14-cycle grant spacing
    @(posedge fclk);
    rstn = 1'b0;
    @(posedge fclk);
    rstn = 1'b1;
    bus_if.tx_len = 8'd2; bus_if.rx_len = 8'd2;
    bus_if.tx_req = 1'b1; bus_if.rx_req = 1'b1;
    capture(56, 1'b1, -1, 0);
    bus_if.tx_req = 1'b0; bus_if.rx_req = 1'b0;
    e_jesd = '0; e_done = '0; e_rd = '0; e_wr = '0; e_txnrx = '0;
    e_busy = 64'h00FF_FFFF_FFFF_FFFF;
    for (int b = 0; b < 4; b++) begin
      e_jesd = e_jesd | (64'h108 << (14 * b));
      e_done = e_done | (64'h200 << (14 * b));
      e_busy = e_busy & ~(64'h2000 << (14 * b));
      if (b % 2 == 0) begin
        e_rd    = e_rd | (64'hC0 << (14 * b));
        e_txnrx = e_txnrx | (64'h3FFF << (14 * b));
      end else begin
        e_wr = e_wr | (64'hC0 << (14 * b));
      end
    end
    chk("ct_txnrx", t_txnrx, e_txnrx);
    chk("ct_rd_en", t_rd,    e_rd);
    chk("ct_wr_en", t_wr,    e_wr);
    chk("ct_jesd",  t_jesd,  e_jesd);
    chk("ct_done",  t_done,  e_done);
    chk("ct_busy",  t_busy,  e_busy);

    // Gating: prog_full blocks RX, zero length blocks TX
    bus_if.rx_len = 8'd4; bus_if.rx_req = 1'b1;
    bus_if.fifo_prog_full = 1'b1;
    bus_if.tx_len = 8'd0; bus_if.tx_req = 1'b1;
    capture(6, 1'b1, -1, 0);
    chk("gate_busy", t_busy, 64'h0);
    chk("gate_done", t_done, 64'h0);
    bus_if.fifo_prog_full = 1'b0;
    @(posedge fclk);
    chk("gate_rx_grant_busy",  64'(bus_if.busy), 64'd1);
    chk("gate_rx_grant_txnrx", 64'(bus_if.tx_nrx), 64'd0);
    bus_if.rx_req = 1'b0; bus_if.tx_req = 1'b0;
    wait_idle();

    // Reset in the middle of an RX XFER
    bus_if.rx_len = 8'd8; bus_if.rx_req = 1'b1;
    capture(8, 1'b0, -1, 0);
    chk("mid_wr_en_before", t_wr, 64'hC0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_wr_en",  64'(bus_if.fifo_wr_en), 64'd0);
    chk("mid_rst_jesd",   64'(bus_if.jesd_en), 64'd0);
    chk("mid_rst_tx_nrx", 64'(bus_if.tx_nrx), 64'd1);
    chk("mid_rst_busy",   64'(bus_if.busy), 64'd0);
    chk("mid_rst_rd_en",  64'(bus_if.fifo_rd_en), 64'd0);
    @(posedge fclk);
    rstn = 1'b1;

    // Normal TX grant after release, len 1
    bus_if.tx_len = 8'd1; bus_if.tx_req = 1'b1;
    capture(16, 1'b0, -1, 0);
    chk("post_txnrx", t_txnrx, 64'hFFFF);
    chk("post_jesd",  t_jesd,  64'h88);
    chk("post_rd_en", t_rd,    64'h40);
    chk("post_wr_en", t_wr,    64'h0);
    chk("post_done",  t_done,  64'h100);
    chk("post_busy",  t_busy,  64'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
